// File: rtl/bound_flasher_param.sv
// bound_flasher_param
//   Thermometer lamp sequencer. Each run is made of six phases:
//   ramp up to N, down to LO, up to HI, down to 0, up to LO, then down to 0.
//   A flick held at a boundary during the ramp phases kicks the bar back:
//   - UP1 falls back to 0.
//   - UP2 falls back to LO.
//   A prescaler spaces the lamp steps DIV clocks apart.
//
// Parameters
//   N        lamp count (4..64)
//   LO, HI   bound positions as lit-lamp counts, 0 < LO < HI < N
//   DIV      clocks per lamp step (1..65535)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-low reset
//   flick    start request; also a kickback request at UP1/UP2 bounds
//   cont     at completion, restart at UP1 instead of returning to IDLE
//   lamp     thermometer output, lamp[i] = (i < k)
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse on the step that finishes DN3
module bound_flasher_param #(
   parameter int N   = 16,
   parameter int LO  = 5,
   parameter int HI  = 10,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flick,
   input  logic         cont,
   output logic [N-1:0] lamp,
   output logic         busy,
   output logic         done
);

   localparam int KW = (N + 1 > 2) ? $clog2(N + 1) : 1;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [KW-1:0] K_N   = KW'(N);
   localparam logic [KW-1:0] K_LO  = KW'(LO);
   localparam logic [KW-1:0] K_HI  = KW'(HI);
   localparam logic [KW-1:0] K_0   = '0;
   localparam logic [PW-1:0] P_TOP = PW'(DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_UP1, S_DN1, S_UP2, S_DN2, S_UP3, S_DN3, S_KB1, S_KB2
   } state_t;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [PW-1:0]   r_pre;
   logic [N-1:0]    r_lamp;
   logic            r_busy;
   logic            r_done;

   logic            w_step;
   logic            w_up;
   logic [KW-1:0]   w_k_inc;
   logic [KW-1:0]   w_k_dec;

   assign w_step  = (r_pre == P_TOP);
   assign w_up    = (r_state == S_UP1) || (r_state == S_UP2) || (r_state == S_UP3);
   assign w_k_inc = r_k + 1'b1;
   assign w_k_dec = r_k - 1'b1;

   // The lamp bar is kept as its own register and shifted alongside k.
   // This keeps the outputs free of any decode logic.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_pre   <= '0;
         r_lamp  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            r_pre <= '0;
            if (flick) begin
               r_state <= S_UP1;
               r_k     <= '0;
               r_lamp  <= '0;
               r_busy  <= 1'b1;
            end
         end else begin
            r_pre <= w_step ? '0 : r_pre + 1'b1;
            if (w_step) begin
               if (w_up) begin
                  r_k    <= w_k_inc;
                  r_lamp <= {r_lamp[N-2:0], 1'b1};
               end else begin
                  r_k    <= w_k_dec;
                  r_lamp <= {1'b0, r_lamp[N-1:1]};
               end
               // The transition happens on the step that writes the target.
               // The next phase moves k on the following step, which gives
               // one step of dwell at each turnaround.
               case (r_state)
                  S_UP1: begin
                     if (w_k_inc == K_N)
                        r_state <= S_DN1;
                     else if (flick && (w_k_inc == K_LO || w_k_inc == K_HI))
                        r_state <= S_KB1;
                  end
                  S_DN1: if (w_k_dec == K_LO) r_state <= S_UP2;
                  S_UP2: if (w_k_inc == K_HI) r_state <= flick ? S_KB2 : S_DN2;
                  S_DN2: if (w_k_dec == K_0)  r_state <= S_UP3;
                  S_UP3: if (w_k_inc == K_LO) r_state <= S_DN3;
                  S_DN3: begin
                     if (w_k_dec == K_0) begin
                        r_done <= 1'b1;
                        if (cont) begin
                           r_state <= S_UP1;
                        end else begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                        end
                     end
                  end
                  S_KB1: if (w_k_dec == K_0)  r_state <= S_UP1;
                  S_KB2: if (w_k_dec == K_LO) r_state <= S_UP2;
                  default: begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign lamp = r_lamp;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: doc/bound_flasher_param.md
BOUND_FLASHER_PARAM -- requirements
Module: bound_flasher_param

Interface
REQ-001 Parameter N, default 16: lamp count; legal range 4..64.
REQ-002 Parameter LO, default 5: lower bound, expressed as a count of lit lamps; 0 < LO < HI.
REQ-003 Parameter HI, default 10: upper bound, expressed as a count of lit lamps; HI < N.
REQ-004 Parameter DIV, default 1: clocks per lamp step; legal range 1..65535.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port flick, input, 1 bit: start request and kickback request.
REQ-008 Port cont, input, 1 bit: 1 = restart the sequence after it completes, instead of idling.
REQ-009 Port lamp, output, N bits: thermometer pattern; lamp[i] = 1 iff i < k, where k (0..N) is the lit count.
REQ-010 Port busy, output, 1 bit: 1 whenever state != IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse at sequence completion.

Function
REQ-012 States SHALL be IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KB1, KB2.
REQ-013 Prescaler pre SHALL count 0..DIV-1 while state != IDLE; a "step edge" is an edge with pre == DIV-1.
REQ-014 pre SHALL be held at 0 in IDLE and SHALL wrap to 0 on each step edge.
REQ-015 k SHALL change only on step edges, by exactly +1 (UP*) or -1 (DN*, KB*).
REQ-016 IDLE SHALL hold k = 0; flick = 1 on any edge in IDLE SHALL move the state to UP1 with k = 0 and pre = 0.
REQ-017 Phase targets: UP1 0->N, DN1 N->LO, UP2 LO->HI, DN2 HI->0, UP3 0->LO, DN3 LO->0.
REQ-018 On the step edge that writes a phase's target value, the state SHALL advance to the next phase in that same edge.
REQ-019 The new phase's first step SHALL occur on the following step edge, giving one step of dwell at each turnaround.
REQ-020 UP1 kickback: on a step edge that writes k = LO or k = HI while flick = 1, the state SHALL become KB1.
REQ-021 KB1 SHALL decrement k; when it writes k = 0 the state SHALL return to UP1.
REQ-022 UP2 kickback: on the step edge that writes k = HI while flick = 1, the state SHALL become KB2 instead of DN2.
REQ-023 KB2 SHALL decrement k; when it writes k = LO the state SHALL return to UP2.
REQ-024 flick SHALL be sampled only on IDLE edges and on the boundary step edges of REQ-020/REQ-022; flick is ignored elsewhere.
REQ-025 A kickback SHALL repeat each time its boundary is reached while flick = 1.
REQ-026 DN3 completion: on the step edge writing k = 0, done SHALL be 1 for exactly that cycle.
REQ-027 At DN3 completion the state SHALL become UP1 if cont = 1, else IDLE; cont is sampled at that edge only.
REQ-028 lamp, busy and done SHALL be driven directly from registers (no combinational path from any input).
REQ-029 k and pre widths SHALL be clog2(N+1) and clog2(DIV) bits, minimum 1 bit each; no overflow is reachable.

Reset
REQ-030 On an edge with reset = 0: state = IDLE, k = 0 (lamp = 0), pre = 0, busy = 0, done = 0; this overrides flick and any mid-phase activity.
REQ-031 The first edge with reset = 1 SHALL behave as a normal IDLE edge.

Verification (N=16, LO=5, HI=10, DIV=1 unless stated)
REQ-032 reset low for 3 clocks with flick toggling -> lamp = 16'h0000, busy = 0, done = 0 throughout.
REQ-033 one-cycle flick pulse at edge t, cont = 0 ->
- lamp = 16'h0001 at t+2 and 16'hFFFF at t+17;
- 52 steps in total; lamp = 0 and done = 1 at t+53, then busy = 0.
REQ-034 flick held at 1 from start -> k ramps 0..5, falls to 0, repeats indefinitely; after release, the next pass reaches 16'hFFFF.
REQ-035 flick = 1 only on the edge where UP2 writes k = 10 -> k falls 9..5, then ramps 6..10, then DN2 runs.
REQ-036 cont = 1 -> at completion done pulses while busy stays 1, and lamp = 16'h0001 one cycle later.
REQ-037 reset low during DN1 at k = 12 -> lamp = 0 on the next edge; a later flick restarts from UP1.
REQ-038 DIV = 4 -> k changes exactly every 4 clocks; completion at t+1+52*4.
